// File: rtl/display_char_feeder_if.sv
// Host-to-terminal character feeder bus: host push side plus terminal handshake side.
// master = host/terminal environment, slave = display_char_feeder.
interface display_char_feeder_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic [7:1] rd;
    logic       da;
    logic       rda_n;

    modport master (
        output wr_en, wr_data, rda_n,
        input  full, empty, overflow, busy, rd, da
    );

    modport slave (
        input  wr_en, wr_data, rda_n,
        output full, empty, overflow, busy, rd, da
    );
endinterface

// File: rtl/display_char_feeder.sv
// Buffers host ASCII bytes and presents them one at a time to the display terminal (rd/da, rda_n ack).
// Optional build macro FEEDER_UPCASE_EN: lower-case letters are sent as upper case.
module display_char_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SETUP_CYC = 2
) (
    input  logic                 clk,
    input  logic                 mr_n,
    display_char_feeder_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SCNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ASSERT  = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    logic [6:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              sync1_q, rda_s_q;
    state_e            state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [6:0]        rd_q, rd_d;
    logic              da_q, da_d;
    logic              busy_q, busy_d;
    logic              push_c, pop_c;
    logic [6:0]        head_c, load_c;
    logic              unused_wr_bit7;

    assign unused_wr_bit7 = bus.wr_data[7];
    assign head_c         = mem[rd_ptr_q];

    // Character presented to the terminal for the current head byte
`ifdef FEEDER_UPCASE_EN
    assign load_c = (head_c >= 7'h61 && head_c <= 7'h7A) ? head_c - 7'h20 : head_c;
`else
    assign load_c = head_c;
`endif

    // FIFO bookkeeping and handshake sequencing
    always_comb begin
        pop_c      = (state_q == S_IDLE) && !empty_q;
        // A pop in the same cycle frees the slot, so a push while full is legal then
        push_c     = bus.wr_en && (!full_q || pop_c);
        overflow_d = overflow_q | (bus.wr_en && full_q && !pop_c);

        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));

        state_d = state_q;
        scnt_d  = scnt_q;
        rd_d    = rd_q;
        da_d    = da_q;
        case (state_q)
            S_IDLE: begin
                da_d = 1'b0;
                if (pop_c) begin
                    rd_d    = load_c;
                    scnt_d  = SCNT_W'(SETUP_CYC);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                da_d = 1'b0;
                if (scnt_q != SCNT_W'(0)) begin
                    scnt_d = scnt_q - SCNT_W'(1);
                end
                // Counter reaching zero on this edge; wait out any ack still held low
                if (scnt_q <= SCNT_W'(1) && rda_s_q) begin
                    da_d    = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (!rda_s_q) begin
                    da_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                da_d = 1'b0;
                if (rda_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                da_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            sync1_q    <= 1'b1;
            rda_s_q    <= 1'b1;
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            rd_q       <= 7'h00;
            da_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            sync1_q    <= bus.rda_n;
            rda_s_q    <= sync1_q;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            rd_q       <= rd_d;
            da_q       <= da_d;
            busy_q     <= busy_d;
        end
    end

    // Storage needs no reset; occupancy tracking alone defines valid entries
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= bus.wr_data[6:0];
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.rd       = rd_q;
    assign bus.da       = da_q;

endmodule

// File: tb/tb_display_char_feeder.sv
// Self-checking bench for display_char_feeder: a terminal model acks characters and
// compares them against a queue of expected characters derived from the pushed bytes.
module tb_display_char_feeder;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned SETUP_CYC = 2;

    logic clk;
    logic mr_n;
    int   n_checks;
    int   n_fail;
    logic [6:0] exp_q [$];

    display_char_feeder_if bus ();

    display_char_feeder #(.DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC)) dut (
        .clk  (clk),
        .mr_n (mr_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // Reference mapping from a host byte to the character the terminal should see
    function automatic logic [6:0] ref_char(input logic [7:0] b);
        int c;
        c = int'(b) % 128;
`ifdef FEEDER_UPCASE_EN
        if (c >= 97 && c <= 122) c = c - 32;
`endif
        return 7'(c);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        exp_q.push_back(ref_char(b));
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Terminal side: wait for da, check the character, ack, and check the release timing
    task automatic term_recv(input int hold);
        logic [6:0] exp;
        int  waited;
        bit  stable;
        exp = exp_q.pop_front();
        waited = 0;
        while (bus.da !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.da !== 1'b1) begin
            n_fail++;
            $display("FAIL term_da_wait: da=%b after %0d cycles, required 1", bus.da, waited);
        end
        n_checks++;
        if (bus.rd !== exp) begin
            n_fail++;
            $display("FAIL term_rd: rd=%h required %h", bus.rd, exp);
        end
        stable = 1'b1;
        repeat (hold) begin
            tick();
            if (bus.da !== 1'b1 || bus.rd !== exp) stable = 1'b0;
        end
        bus.rda_n = 1'b0;
        tick();
        tick();
        if (bus.da !== 1'b1 || bus.rd !== exp) stable = 1'b0;
        tick();
        n_checks++;
        if (bus.da !== 1'b0) begin
            n_fail++;
            $display("FAIL term_da_fall: da=%b two edges after ack, required 0", bus.da);
        end
        repeat ($urandom_range(1, 3)) begin
            tick();
            if (bus.rd !== exp || bus.da !== 1'b0) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL term_rd_stable: rd/da changed during handshake, required stable rd=%h", exp);
        end
        bus.rda_n = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL term_busy_idle: busy=%b after ack release, required 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        mr_n        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rda_n   = 1'b1;
        exp_q.delete();
        tick();
        tick();
        n_checks++;
        if ({bus.rd, bus.da, bus.empty, bus.full, bus.overflow, bus.busy} !== {7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rd=%h da=%b empty=%b full=%b ovf=%b busy=%b, required 00 0 1 0 0 0",
                     bus.rd, bus.da, bus.empty, bus.full, bus.overflow, bus.busy);
        end
        mr_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push(8'hC1);
        tick();
        n_checks++;
        if (bus.rd !== 7'h41 || bus.busy !== 1'b1 || bus.da !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: rd=%h busy=%b da=%b at N+1, required 41 1 0", bus.rd, bus.busy, bus.da);
        end
        tick();
        n_checks++;
        if (bus.da !== 1'b0) begin
            n_fail++;
            $display("FAIL single_setup: da=%b at N+2, required 0", bus.da);
        end
        tick();
        n_checks++;
        if (bus.da !== 1'b1) begin
            n_fail++;
            $display("FAIL single_da_rise: da=%b at N+%0d, required 1", bus.da, 1 + SETUP_CYC);
        end
        term_recv(5);
    endtask

    task automatic test_hold_ack();
        bit quiet;
        bus.rda_n = 1'b0;
        repeat (3) tick();
        push(8'h8D);
        quiet = 1'b1;
        repeat (10) begin
            tick();
            if (bus.da !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1 || bus.rd !== 7'h0D || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_setup: quiet=%b rd=%h busy=%b, required 1 0d 1", quiet, bus.rd, bus.busy);
        end
        bus.rda_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.da !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_early: da=%b one edge after sync, required 0", bus.da);
        end
        tick();
        n_checks++;
        if (bus.da !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: da=%b two edges after rda_n high, required 1", bus.da);
        end
        term_recv($urandom_range(0, 3));
    endtask

    task automatic test_overflow();
        push(8'h2A);
        while (bus.da !== 1'b1) tick();
        for (int i = 0; i < 17; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h30 + i);
            if (i < 16) exp_q.push_back(ref_char(8'(8'h30 + i)));
            tick();
            if (i == 15) begin
                n_checks++;
                if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: full=%b ovf=%b after 16 pushes, required 1 0", bus.full, bus.overflow);
                end
            end
        end
        bus.wr_en = 1'b0;
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b full=%b after 17th push, required 1 1", bus.overflow, bus.full);
        end
        while (exp_q.size() > 0) term_recv($urandom_range(0, 2));
        n_checks++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: empty=%b ovf=%b, required 1 1", bus.empty, bus.overflow);
        end
    endtask

    task automatic test_push_pop_full();
        int guard;
        logic [7:0] extra;
        push(8'h21);
        while (bus.da !== 1'b1) tick();
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        bus.rda_n = 1'b0;
        while (bus.da !== 1'b0) tick();
        void'(exp_q.pop_front());
        bus.rda_n = 1'b1;
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 20) begin
            tick();
            guard++;
        end
        extra       = 8'($urandom_range(0, 255));
        bus.wr_en   = 1'b1;
        bus.wr_data = extra;
        exp_q.push_back(ref_char(extra));
        tick();
        bus.wr_en   = 1'b0;
        n_checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_full: full=%b ovf=%b after push+pop at full, required 1 0", bus.full, bus.overflow);
        end
        while (exp_q.size() > 0) term_recv($urandom_range(0, 2));
        n_checks++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_drain: empty=%b ovf=%b, required 1 0", bus.empty, bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        push(8'h55);
        push(8'h56);
        while (bus.da !== 1'b1) tick();
        #2;
        mr_n = 1'b0;
        #1;
        n_checks++;
        if (bus.da !== 1'b0 || bus.rd !== 7'h00 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: da=%b rd=%h empty=%b before next edge, required 0 00 1", bus.da, bus.rd, bus.empty);
        end
        exp_q.delete();
        tick();
        mr_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            tick();
            if (bus.da !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_quiet: da/busy activity after reset release, required none");
        end
    endtask

    task automatic test_upcase();
        push(8'h61);
        push(8'h7A);
        push(8'h7B);
        push(8'h60);
        push(8'hE1);
        while (exp_q.size() > 0) term_recv($urandom_range(0, 2));
    endtask

    task automatic test_random();
        int n;
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        while (exp_q.size() > 0) term_recv($urandom_range(0, 4));
        n_checks++;
        if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_end: empty=%b busy=%b, required 1 0", bus.empty, bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_hold_ack();
        test_reset();
        test_overflow();
        test_reset();
        test_push_pop_full();
        test_reset_mid();
        test_upcase();
        for (int r = 0; r < 4; r++) test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
